cla_pipe_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 18 +
 rtl/cla_4bit_group.sv | 22 ++
 rtl/cla_pipe_adder.sv | 186 ++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int GRP_W = 4;

  // Returns {P, G} of one 4-bit lookahead group.
  function automatic logic [1:0] grp_pg(input logic [GRP_W-1:0] p, input logic [GRP_W-1:0] g);
    logic gen;
    gen = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {&p, gen};
  endfunction

  // Legal geometry: whole lanes per word, whole groups per lane.
  function automatic bit cfg_ok(input int width, input int lane_w);
    return (lane_w > 0) && (width >= lane_w) && (width % lane_w == 0) && (lane_w % GRP_W == 0);
  endfunction

endpackage

// File: rtl/cla_4bit_group.sv
// One 4-bit carry-lookahead group: internal carries, carry-out and group P/G.
module cla_4bit_group
  import cla_pkg::*;
(
  input  logic [GRP_W-1:0] p,
  input  logic [GRP_W-1:0] g,
  input  logic             cin,
  output logic [3:1]       c,
  output logic             cout,
  output logic             P,
  output logic             G
);

  // P/G kept apart from the carry equations so they never depend on cin.
  assign {P, G} = grp_pg(p, g);

  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = G | (P & cin);

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one LANE_W-bit lane resolved per
// stage, lane carry registered between stages, valid/ready stream handshake.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LANE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c0,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             PG,
  output logic             GG,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int LAT = WIDTH / LANE_W;
  localparam int NG  = LANE_W / GRP_W;

  if (!cfg_ok(WIDTH, LANE_W)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a multiple of LANE_W and LANE_W a multiple of 4");
  end

  logic             adv;
  logic             v_q   [LAT];
  logic [WIDTH-1:0] a_q   [LAT];
  logic [WIDTH-1:0] be_q  [LAT];
  logic [WIDTH-1:0] s_q   [LAT];
  logic             c_q   [LAT];
  logic             pg_q  [LAT];
  logic             gg_q  [LAT];
  logic             ovf_q [LAT];

  // The whole pipe stalls as one unit whenever the held result is not taken.
  assign adv       = !v_q[LAT-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[LAT-1];
  assign sum       = s_q[LAT-1];
  assign Cout      = c_q[LAT-1];
  assign PG        = pg_q[LAT-1];
  assign GG        = gg_q[LAT-1];
  assign ovf       = ovf_q[LAT-1];

  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    localparam int LO = gi * LANE_W;

    logic             v_in, c_in, pg_in, gg_in;
    logic [WIDTH-1:0] a_in, be_in, s_in;

    // Operands are shifted down one lane per stage, so the active lane is always at the bottom.
    if (gi == 0) begin : g_head
      assign v_in  = in_valid;
      assign a_in  = A;
      assign be_in = sub ? ~B : B;
      assign c_in  = sub ? ~c0 : c0;
      assign s_in  = '0;
      assign pg_in = 1'b1;
      assign gg_in = 1'b0;
    end else begin : g_body
      assign v_in  = v_q[gi-1];
      assign a_in  = a_q[gi-1];
      assign be_in = be_q[gi-1];
      assign c_in  = c_q[gi-1];
      assign s_in  = s_q[gi-1];
      assign pg_in = pg_q[gi-1];
      assign gg_in = gg_q[gi-1];
    end

    logic [LANE_W-1:0] lp, lg, cb, lsum;
    logic [NG-1:0]     grp_p, grp_g, grp_cin, grp_co;
    logic [3:1]        grp_c [NG];
    logic              lane_p, lane_g;

    assign lp = a_in[LANE_W-1:0] ^ be_in[LANE_W-1:0];
    assign lg = a_in[LANE_W-1:0] & be_in[LANE_W-1:0];

    for (genvar gj = 0; gj < NG; gj++) begin : g_grp
      cla_4bit_group u_grp (
        .p   (lp[gj*GRP_W +: GRP_W]),
        .g   (lg[gj*GRP_W +: GRP_W]),
        .cin (grp_cin[gj]),
        .c   (grp_c[gj]),
        .cout(grp_co[gj]),
        .P   (grp_p[gj]),
        .G   (grp_g[gj])
      );
    end

    // Group carry-ins and lane P/G as flat sum-of-products over group P/G.
    always_comb begin
      logic acc, pall;
      acc     = 1'b0;
      pall    = 1'b1;
      grp_cin = '0;
      grp_cin[0] = c_in;
      for (int j = 1; j < NG; j++) begin
        acc  = 1'b0;
        pall = 1'b1;
        for (int i = j - 1; i >= 0; i--) begin
          acc  = acc | (grp_g[i] & pall);
          pall = pall & grp_p[i];
        end
        grp_cin[j] = acc | (pall & c_in);
      end
      acc  = 1'b0;
      pall = 1'b1;
      for (int i = NG - 1; i >= 0; i--) begin
        acc  = acc | (grp_g[i] & pall);
        pall = pall & grp_p[i];
      end
      lane_p = &grp_p;
      lane_g = acc;
    end

    // A group's first bit takes the previous group's carry-out, equal to the lookahead carry.
    always_comb begin
      cb    = '0;
      cb[0] = c_in;
      for (int j = 0; j < NG; j++) begin
        cb[j*GRP_W + 1 +: 3] = grp_c[j];
      end
      for (int j = 1; j < NG; j++) begin
        cb[j*GRP_W] = grp_co[j-1];
      end
      lsum = lp ^ cb;
    end

    logic             v_d, c_d, pg_d, gg_d, ovf_d;
    logic [WIDTH-1:0] a_d, be_d, s_d;

    always_comb begin
      v_d   = v_q[gi];
      a_d   = a_q[gi];
      be_d  = be_q[gi];
      s_d   = s_q[gi];
      c_d   = c_q[gi];
      pg_d  = pg_q[gi];
      gg_d  = gg_q[gi];
      ovf_d = ovf_q[gi];
      if (adv) begin
        v_d = v_in;
        if (v_in) begin
          a_d   = a_in >> LANE_W;
          be_d  = be_in >> LANE_W;
          s_d   = s_in | (WIDTH'(lsum) << LO);
          c_d   = grp_co[NG-1];
          pg_d  = pg_in & lane_p;
          gg_d  = lane_g | (lane_p & gg_in);
          ovf_d = grp_c[NG-1][3] ^ grp_co[NG-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[gi]   <= 1'b0;
        a_q[gi]   <= '0;
        be_q[gi]  <= '0;
        s_q[gi]   <= '0;
        c_q[gi]   <= 1'b0;
        pg_q[gi]  <= 1'b0;
        gg_q[gi]  <= 1'b0;
        ovf_q[gi] <= 1'b0;
      end else begin
        v_q[gi]   <= v_d;
        a_q[gi]   <= a_d;
        be_q[gi]  <= be_d;
        s_q[gi]   <= s_d;
        c_q[gi]   <= c_d;
        pg_q[gi]  <= pg_d;
        gg_q[gi]  <= gg_d;
        ovf_q[gi] <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder at WIDTH=32, LANE_W=8 (four-cycle latency).
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        c0 = 1'b0;
  logic        sub = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] sum;
  logic        cout, pg, gg, ovf, out_valid;
  logic        out_ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] bp_a   [8];
  logic [31:0] bp_b   [8];
  logic        bp_c0  [8];
  logic        bp_sub [8];
  logic [31:0] bp_sum [8];
  logic        bp_co  [8];
  logic        bp_ov  [8];
  logic        bp_done;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(32), .LANE_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (a),
    .B        (b),
    .c0       (c0),
    .sub      (sub),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum      (sum),
    .Cout     (cout),
    .PG       (pg),
    .GG       (gg),
    .ovf      (ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Issues one op into an idle pipe with out_ready=1; lat counts cycles to out_valid (0 = never).
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc, input logic ts,
                        output int lat, output logic [31:0] s, output logic co, output logic p,
                        output logic g, output logic ov);
    @(posedge clk); #1;
    a = ta; b = tb; c0 = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    s = sum; co = cout; p = pg; g = gg; ov = ovf;
    $display("op a=%h b=%h c0=%b sub=%b -> sum=%h cout=%b pg=%b gg=%b ovf=%b lat=%0d",
             ta, tb, tc, ts, s, co, p, g, ov, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, sum, cout, pg, gg, ovf} !== 37'd0) begin
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b pg=%b gg=%b ovf=%b want all zero",
               out_valid, sum, cout, pg, gg, ovf);
      n_err++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
      n_err++;
    end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_add();
    int lat; logic [31:0] s; logic co, p, g, ov;
    run_op(32'h000002EB, 32'h00005555, 1'b0, 1'b0, lat, s, co, p, g, ov);
    n_vec++;
    if (lat !== 4) begin $display("FAIL add_latency: got %0d want 4", lat); n_err++; end
    n_vec++;
    if (s !== 32'h00005840) begin $display("FAIL add_sum: got %h want 00005840", s); n_err++; end
    n_vec++;
    if ({co, p, g, ov} !== 4'b0000) begin
      $display("FAIL add_flags: got cout/pg/gg/ovf=%b%b%b%b want 0000", co, p, g, ov); n_err++;
    end
  endtask

  task automatic test_carry_ripple();
    int lat; logic [31:0] s; logic co, p, g, ov;
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, lat, s, co, p, g, ov);
    n_vec++;
    if (s !== 32'h00000000) begin $display("FAIL ripple_sum: got %h want 00000000", s); n_err++; end
    n_vec++;
    if ({co, p, g, ov} !== 4'b1100) begin
      $display("FAIL ripple_flags: got cout/pg/gg/ovf=%b%b%b%b want 1100", co, p, g, ov); n_err++;
    end
  endtask

  task automatic test_subtract();
    int lat; logic [31:0] s; logic co, p, g, ov;
    run_op(32'd5, 32'd7, 1'b0, 1'b1, lat, s, co, p, g, ov);
    n_vec++;
    if (s !== 32'hFFFFFFFE) begin $display("FAIL sub57_sum: got %h want fffffffe", s); n_err++; end
    n_vec++;
    if ({co, ov} !== 2'b00) begin $display("FAIL sub57_flags: got cout/ovf=%b%b want 00", co, ov); n_err++; end
    run_op(32'd7, 32'd5, 1'b0, 1'b1, lat, s, co, p, g, ov);
    n_vec++;
    if (s !== 32'h00000002) begin $display("FAIL sub75_sum: got %h want 00000002", s); n_err++; end
    n_vec++;
    if ({co, g, ov} !== 3'b110) begin
      $display("FAIL sub75_flags: got cout/gg/ovf=%b%b%b want 110", co, g, ov); n_err++;
    end
    run_op(32'd7, 32'd5, 1'b1, 1'b1, lat, s, co, p, g, ov);
    n_vec++;
    if ({s, co} !== {32'h00000001, 1'b1}) begin
      $display("FAIL sub75_borrow: got sum=%h cout=%b want 00000001 1", s, co); n_err++;
    end
  endtask

  task automatic test_overflow();
    int lat; logic [31:0] s; logic co, p, g, ov;
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat, s, co, p, g, ov);
    n_vec++;
    if ({s, co, ov} !== {32'h80000000, 1'b0, 1'b1}) begin
      $display("FAIL ovf_add: got sum=%h cout=%b ovf=%b want 80000000 0 1", s, co, ov); n_err++;
    end
    run_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, lat, s, co, p, g, ov);
    n_vec++;
    if ({s, co, ov} !== {32'h7FFFFFFF, 1'b1, 1'b1}) begin
      $display("FAIL ovf_sub: got sum=%h cout=%b ovf=%b want 7fffffff 1 1", s, co, ov); n_err++;
    end
  endtask

  task automatic test_backpressure();
    bp_a   = '{32'h00000001, 32'h00000010, 32'hFFFFFFFF, 32'h00000000,
               32'h12345678, 32'h00000100, 32'h80000000, 32'hAAAAAAAA};
    bp_b   = '{32'h00000001, 32'h00000001, 32'h00000002, 32'h00000001,
               32'h11111111, 32'h00000001, 32'h80000000, 32'h55555555};
    bp_c0  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bp_sub = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bp_sum = '{32'h00000002, 32'h0000000F, 32'h00000001, 32'hFFFFFFFF,
               32'h2345678A, 32'h000000FE, 32'h00000000, 32'h55555555};
    bp_co  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bp_ov  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bp_done = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin : producer
        for (int i = 0; i < 8; i++) begin
          logic acc;
          a = bp_a[i]; b = bp_b[i]; c0 = bp_c0[i]; sub = bp_sub[i]; in_valid = 1'b1;
          acc = 1'b0;
          for (int w = 0; w < 50 && !acc; w++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
          end
          if (!acc) begin
            $display("FAIL bp_accept_timeout: op %0d got not accepted want accepted", i);
            n_err++; n_vec++;
          end
        end
        in_valid = 1'b0;
      end
      begin : consumer
        int k;
        logic prev_stall;
        logic [36:0] prev_out;
        k = 0;
        prev_stall = 1'b0;
        prev_out = '0;
        for (int cyc = 0; cyc < 300 && k < 8; cyc++) begin
          @(negedge clk);
          n_vec++;
          if (in_ready !== !(out_valid && !out_ready)) begin
            $display("FAIL bp_in_ready: got %b want %b (valid=%b ready=%b)",
                     in_ready, !(out_valid && !out_ready), out_valid, out_ready);
            n_err++;
          end
          if (prev_stall) begin
            n_vec++;
            if ({out_valid, sum, cout, ovf, pg, gg} !== prev_out) begin
              $display("FAIL bp_stall_hold: got %h want %h", {out_valid, sum, cout, ovf, pg, gg}, prev_out);
              n_err++;
            end
          end
          prev_stall = out_valid && !out_ready;
          prev_out = {out_valid, sum, cout, ovf, pg, gg};
          if (out_valid && out_ready) begin
            $display("bp result %0d: sum=%h cout=%b ovf=%b", k, sum, cout, ovf);
            n_vec++;
            if (sum !== bp_sum[k]) begin
              $display("FAIL bp_sum[%0d]: got %h want %h", k, sum, bp_sum[k]); n_err++;
            end
            n_vec++;
            if ({cout, ovf} !== {bp_co[k], bp_ov[k]}) begin
              $display("FAIL bp_flags[%0d]: got cout/ovf=%b%b want %b%b", k, cout, ovf, bp_co[k], bp_ov[k]);
              n_err++;
            end
            k++;
          end
        end
        if (k < 8) begin
          $display("FAIL bp_results_timeout: got %0d results want 8", k);
          n_err++; n_vec++;
        end
        bp_done = 1'b1;
      end
      begin : toggler
        while (!bp_done) begin
          @(posedge clk); #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_midflight();
    int lat, seen; logic [31:0] s; logic co, p, g, ov;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h00000100 * (i + 1); b = 32'h00000001; c0 = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if ({out_valid, sum, cout, pg, gg, ovf} !== 37'd0) begin
      $display("FAIL midrst_outputs: got valid=%b sum=%h cout=%b pg=%b gg=%b ovf=%b want all zero",
               out_valid, sum, cout, pg, gg, ovf);
      n_err++;
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_vec++;
    if (seen !== 0) begin $display("FAIL midrst_stale: got %0d results want 0", seen); n_err++; end
    run_op(32'h00001234, 32'h00004321, 1'b0, 1'b0, lat, s, co, p, g, ov);
    n_vec++;
    if (lat !== 4) begin $display("FAIL midrst_latency: got %0d want 4", lat); n_err++; end
    n_vec++;
    if (s !== 32'h00005555) begin $display("FAIL midrst_sum: got %h want 00005555", s); n_err++; end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_ripple();
    test_subtract();
    test_overflow();
    test_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
